// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared register bit positions, oversample ratios and FSM
//               state encodings for the buffered UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_txsta_tx9  = 6;
    localparam int c_txsta_txen = 5;
    localparam int c_txsta_brgh = 2;
    localparam int c_txsta_trmt = 1;
    localparam int c_txsta_tx9d = 0;

    localparam int c_rcsta_spen = 7;
    localparam int c_rcsta_rx9  = 6;
    localparam int c_rcsta_cren = 4;
    localparam int c_rcsta_ferr = 2;
    localparam int c_rcsta_oerr = 1;
    localparam int c_rcsta_rx9d = 0;

    localparam int c_os_hi = 16;
    localparam int c_os_lo = 64;

    typedef enum logic [2:0] {
        TSR_IDLE  = 3'd0,
        TSR_START = 3'd1,
        TSR_DATA  = 3'd2,
        TSR_NINTH = 3'd3,
        TSR_STOP  = 3'd4
    } tsr_state_t;

    typedef enum logic [2:0] {
        RSR_IDLE  = 3'd0,
        RSR_START = 3'd1,
        RSR_DATA  = 3'd2,
        RSR_NINTH = 3'd3,
        RSR_STOP  = 3'd4
    } rsr_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with registered occupancy; head is read
//               combinationally. Push into a full FIFO is accepted only
//               when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_pw-1:0] c_last = c_pw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_full);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : PIC-style SFR-mapped UART with TX/RX FIFOs, 9-bit frames,
//               8/16-bit baud divisor and majority-vote receive sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int TX_DEPTH  = 1,
    parameter int RX_DEPTH  = 2,
    parameter int BRG_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       UART_TXD,
    input  logic       UART_RXD,
    input  logic [7:0] reg_data_in,
    input  logic       txsta_reg_wr_en,
    output logic [7:0] txsta_reg_out,
    input  logic       rcsta_reg_wr_en,
    output logic [7:0] rcsta_reg_out,
    input  logic       spbrg_reg_wr_en,
    output logic [7:0] spbrg_reg_out,
    input  logic       spbrgh_reg_wr_en,
    output logic [7:0] spbrgh_reg_out,
    input  logic       txreg_reg_wr_en,
    output logic [7:0] txreg_reg_out,
    input  logic       rcreg_reg_rd_en,
    output logic [7:0] rcreg_reg_out,
    output logic       txif_set_en,
    output logic       rxif_set_en
);

    import uart_pkg::*;

    logic r_tx9, r_txen, r_brgh, r_tx9d;
    logic r_spen, r_rx9, r_cren, r_oerr;
    logic [7:0] r_spbrg, r_txreg, w_spbrgh;
    logic [BRG_WIDTH-1:0] w_divisor, r_brg_cnt;
    logic w_tick;
    logic [5:0] w_os_last, w_half;

    // ---------------- baud generator ----------------
    if (BRG_WIDTH == 16) begin : g_brg16
        logic [7:0] r_spbrgh;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_spbrgh <= '0;
            end else if (spbrgh_reg_wr_en) begin
                r_spbrgh <= reg_data_in;
            end
        end
        assign w_spbrgh  = r_spbrgh;
        assign w_divisor = {r_spbrgh, r_spbrg};
    end else begin : g_brg8
        logic w_unused_brgh;
        assign w_unused_brgh = spbrgh_reg_wr_en;
        assign w_spbrgh      = '0;
        assign w_divisor     = r_spbrg;
    end

    assign w_tick    = (r_brg_cnt >= w_divisor);
    assign w_os_last = r_brgh ? 6'(c_os_hi - 1) : 6'(c_os_lo - 1);
    assign w_half    = r_brgh ? 6'(c_os_hi / 2) : 6'(c_os_lo / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brg_cnt <= '0;
        end else begin
            r_brg_cnt <= w_tick ? '0 : r_brg_cnt + 1'b1;
        end
    end

    // ---------------- control registers ----------------
    logic w_rx_push, w_rxf_full, w_rxf_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_tx9, r_txen, r_brgh, r_tx9d} <= '0;
            {r_spen, r_rx9, r_cren, r_oerr} <= '0;
            r_spbrg <= '0;
            r_txreg <= '0;
        end else begin
            if (txsta_reg_wr_en) begin
                r_tx9  <= reg_data_in[c_txsta_tx9];
                r_txen <= reg_data_in[c_txsta_txen];
                r_brgh <= reg_data_in[c_txsta_brgh];
                r_tx9d <= reg_data_in[c_txsta_tx9d];
            end
            if (spbrg_reg_wr_en) r_spbrg <= reg_data_in;
            if (txreg_reg_wr_en) r_txreg <= reg_data_in;
            if (w_rx_push && w_rxf_full && !rcreg_reg_rd_en) r_oerr <= 1'b1;
            if (rcsta_reg_wr_en) begin
                r_spen <= reg_data_in[c_rcsta_spen];
                r_rx9  <= reg_data_in[c_rcsta_rx9];
                r_cren <= reg_data_in[c_rcsta_cren];
                if (!reg_data_in[c_rcsta_cren]) r_oerr <= 1'b0;
            end
        end
    end

    // ---------------- transmit path ----------------
    tsr_state_t r_tsr_state, w_tsr_next;
    logic [5:0] r_tx_sub;
    logic [8:0] r_tx_shift, w_txf_head;
    logic [2:0] r_tx_bitcnt;
    logic       r_tx_begun, r_txd, w_tx_en, w_tx_pop, w_bit_edge, w_txf_full, w_txf_empty;

    assign w_tx_en    = r_txen & r_spen;
    assign w_bit_edge = w_tick & (r_tx_sub >= w_os_last);

    uart_sync_fifo #(.WIDTH(9), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (txreg_reg_wr_en),
        .i_push_data({r_tx9d, reg_data_in}),
        .i_pop      (w_tx_pop),
        .o_head     (w_txf_head),
        .o_full     (w_txf_full),
        .o_empty    (w_txf_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sub <= '0;
        end else if (w_tick) begin
            r_tx_sub <= (r_tx_sub >= w_os_last) ? '0 : r_tx_sub + 1'b1;
        end
    end

    always_comb begin
        w_tsr_next = r_tsr_state;
        w_tx_pop   = 1'b0;
        case (r_tsr_state)
            TSR_IDLE:  if (w_tx_en && !w_txf_empty) begin
                           w_tx_pop   = 1'b1;
                           w_tsr_next = TSR_START;
                       end
            TSR_START: if (w_bit_edge && r_tx_begun) w_tsr_next = TSR_DATA;
            TSR_DATA:  if (w_bit_edge && r_tx_bitcnt == 3'd7)
                           w_tsr_next = r_tx9 ? TSR_NINTH : TSR_STOP;
            TSR_NINTH: if (w_bit_edge) w_tsr_next = TSR_STOP;
            TSR_STOP:  if (w_bit_edge) w_tsr_next = TSR_IDLE;
            default:   w_tsr_next = TSR_IDLE;
        endcase
        if (!w_tx_en) begin
            w_tsr_next = TSR_IDLE;
            w_tx_pop   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tsr_state <= TSR_IDLE;
        else        r_tsr_state <= w_tsr_next;
    end

    // START spends the wait for the first boundary with the line still high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txd       <= 1'b1;
            r_tx_begun  <= 1'b0;
            r_tx_shift  <= '0;
            r_tx_bitcnt <= '0;
        end else if (!w_tx_en) begin
            r_txd      <= 1'b1;
            r_tx_begun <= 1'b0;
        end else begin
            case (r_tsr_state)
                TSR_IDLE: if (w_tx_pop) begin
                    r_tx_shift  <= w_txf_head;
                    r_tx_begun  <= 1'b0;
                    r_tx_bitcnt <= '0;
                end
                TSR_START: if (w_bit_edge) begin
                    if (!r_tx_begun) begin
                        r_txd      <= 1'b0;
                        r_tx_begun <= 1'b1;
                    end else begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                end
                TSR_DATA: if (w_bit_edge) begin
                    if (r_tx_bitcnt == 3'd7) begin
                        r_txd <= r_tx9 ? r_tx_shift[0] : 1'b1;
                    end else begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                    r_tx_bitcnt <= r_tx_bitcnt + 1'b1;
                end
                TSR_NINTH: if (w_bit_edge) r_txd <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- receive path ----------------
    rsr_state_t r_rsr_state, w_rsr_next;
    logic       r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic [5:0] r_rx_sub;
    logic [1:0] r_rx_votes;
    logic [2:0] r_rx_bitcnt;
    logic [7:0] r_rx_shift;
    logic       r_rx_bit9, w_rx_en, w_rx_fall, w_rx_samp, w_rx_decide, w_rx_bit;
    logic [9:0] w_rx_push_data, w_rxf_head;

    assign w_rx_en     = r_spen & r_cren & ~r_oerr;
    assign w_rx_fall   = r_rxd_prev & ~r_rxd_sync;
    assign w_rx_samp   = w_tick & ((r_rx_sub == w_half - 6'd1) || (r_rx_sub == w_half) ||
                                   (r_rx_sub == w_half + 6'd1));
    assign w_rx_decide = w_tick & (r_rx_sub == w_half + 6'd1);
    // Two earlier votes are in r_rx_votes; the third is the current sample.
    assign w_rx_bit    = (r_rx_votes == 2'd2) | ((r_rx_votes == 2'd1) & r_rxd_sync);
    assign w_rx_push_data = {~w_rx_bit, r_rx9 & r_rx_bit9, r_rx_shift};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= UART_RXD;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    always_comb begin
        w_rsr_next = r_rsr_state;
        w_rx_push  = 1'b0;
        case (r_rsr_state)
            RSR_IDLE:  if (w_rx_fall) w_rsr_next = RSR_START;
            RSR_START: if (w_rx_decide) w_rsr_next = w_rx_bit ? RSR_IDLE : RSR_DATA;
            RSR_DATA:  if (w_rx_decide && r_rx_bitcnt == 3'd7)
                           w_rsr_next = r_rx9 ? RSR_NINTH : RSR_STOP;
            RSR_NINTH: if (w_rx_decide) w_rsr_next = RSR_STOP;
            RSR_STOP:  if (w_rx_decide) begin
                           w_rsr_next = RSR_IDLE;
                           w_rx_push  = 1'b1;
                       end
            default:   w_rsr_next = RSR_IDLE;
        endcase
        if (!w_rx_en) begin
            w_rsr_next = RSR_IDLE;
            w_rx_push  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rsr_state <= RSR_IDLE;
        else        r_rsr_state <= w_rsr_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sub    <= '0;
            r_rx_votes  <= '0;
            r_rx_bitcnt <= '0;
            r_rx_shift  <= '0;
            r_rx_bit9   <= 1'b0;
        end else if (r_rsr_state == RSR_IDLE) begin
            r_rx_sub    <= '0;
            r_rx_votes  <= '0;
            r_rx_bitcnt <= '0;
        end else if (w_tick) begin
            r_rx_sub <= (r_rx_sub >= w_os_last) ? '0 : r_rx_sub + 1'b1;
            if (w_rx_decide)                 r_rx_votes <= '0;
            else if (w_rx_samp && r_rxd_sync) r_rx_votes <= r_rx_votes + 2'd1;
            if (w_rx_decide && r_rsr_state == RSR_DATA) begin
                r_rx_shift  <= {w_rx_bit, r_rx_shift[7:1]};
                r_rx_bitcnt <= r_rx_bitcnt + 1'b1;
            end
            if (w_rx_decide && r_rsr_state == RSR_NINTH) r_rx_bit9 <= w_rx_bit;
        end
    end

    uart_sync_fifo #(.WIDTH(10), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_rx_push),
        .i_push_data(w_rx_push_data),
        .i_pop      (rcreg_reg_rd_en),
        .o_head     (w_rxf_head),
        .o_full     (w_rxf_full),
        .o_empty    (w_rxf_empty)
    );

    // Head view is registered so a pop shows up one edge after it is taken.
    logic [7:0] r_rx_head;
    logic       r_rx_ferr, r_rx_9d, r_rxif;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_head <= '0;
            r_rx_ferr <= 1'b0;
            r_rx_9d   <= 1'b0;
            r_rxif    <= 1'b0;
        end else begin
            r_rx_head <= w_rxf_empty ? 8'h00 : w_rxf_head[7:0];
            r_rx_9d   <= ~w_rxf_empty & w_rxf_head[8];
            r_rx_ferr <= ~w_rxf_empty & w_rxf_head[9];
            r_rxif    <= ~w_rxf_empty;
        end
    end

    // ---------------- register read-back ----------------
    always_comb begin
        txsta_reg_out               = '0;
        txsta_reg_out[c_txsta_tx9]  = r_tx9;
        txsta_reg_out[c_txsta_txen] = r_txen;
        txsta_reg_out[c_txsta_brgh] = r_brgh;
        txsta_reg_out[c_txsta_trmt] = (r_tsr_state == TSR_IDLE);
        txsta_reg_out[c_txsta_tx9d] = r_tx9d;
        rcsta_reg_out               = '0;
        rcsta_reg_out[c_rcsta_spen] = r_spen;
        rcsta_reg_out[c_rcsta_rx9]  = r_rx9;
        rcsta_reg_out[c_rcsta_cren] = r_cren;
        rcsta_reg_out[c_rcsta_ferr] = r_rx_ferr;
        rcsta_reg_out[c_rcsta_oerr] = r_oerr;
        rcsta_reg_out[c_rcsta_rx9d] = r_rx_9d;
    end

    assign UART_TXD       = r_txd;
    assign spbrg_reg_out  = r_spbrg;
    assign spbrgh_reg_out = w_spbrgh;
    assign txreg_reg_out  = r_txreg;
    assign rcreg_reg_out  = r_rx_head;
    assign txif_set_en    = ~w_txf_full;
    assign rxif_set_en    = r_rxif;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo
// Description : Directed self-checking bench for uart_fifo (loopback, 9-bit,
//               overrun, framing, false start, 16-bit divisor, async reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;

    localparam int c_sel_txsta  = 0;
    localparam int c_sel_rcsta  = 1;
    localparam int c_sel_spbrg  = 2;
    localparam int c_sel_spbrgh = 3;
    localparam int c_sel_txreg  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       UART_TXD, UART_RXD;
    logic       loop_en = 1'b1;
    logic       rxd_force = 1'b1;
    logic [7:0] reg_data_in = '0;
    logic       txsta_wr = 0, rcsta_wr = 0, spbrg_wr = 0, spbrgh_wr = 0, txreg_wr = 0, rd_en = 0;
    logic [7:0] txsta_out, rcsta_out, spbrg_out, spbrgh_out, txreg_out, rcreg_out;
    logic       txif, rxif;
    int         n_checks = 0;
    int         n_pass = 0;

    assign UART_RXD = loop_en ? UART_TXD : rxd_force;

    always #5 clk = ~clk;

    uart_fifo #(.TX_DEPTH(1), .RX_DEPTH(2), .BRG_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .UART_TXD        (UART_TXD),
        .UART_RXD        (UART_RXD),
        .reg_data_in     (reg_data_in),
        .txsta_reg_wr_en (txsta_wr),
        .txsta_reg_out   (txsta_out),
        .rcsta_reg_wr_en (rcsta_wr),
        .rcsta_reg_out   (rcsta_out),
        .spbrg_reg_wr_en (spbrg_wr),
        .spbrg_reg_out   (spbrg_out),
        .spbrgh_reg_wr_en(spbrgh_wr),
        .spbrgh_reg_out  (spbrgh_out),
        .txreg_reg_wr_en (txreg_wr),
        .txreg_reg_out   (txreg_out),
        .rcreg_reg_rd_en (rd_en),
        .rcreg_reg_out   (rcreg_out),
        .txif_set_en     (txif),
        .rxif_set_en     (rxif)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr_reg(input int sel, input logic [7:0] d);
        reg_data_in = d;
        case (sel)
            c_sel_txsta:  txsta_wr  = 1'b1;
            c_sel_rcsta:  rcsta_wr  = 1'b1;
            c_sel_spbrg:  spbrg_wr  = 1'b1;
            c_sel_spbrgh: spbrgh_wr = 1'b1;
            default:      txreg_wr  = 1'b1;
        endcase
        tick(1);
        {txsta_wr, rcsta_wr, spbrg_wr, spbrgh_wr, txreg_wr} = '0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic wait_txd_fall(input string tag, input int budget);
        int n = 0;
        while (UART_TXD !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, {15'b0, UART_TXD}, 16'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(txsta_out[1] && txif) && n < 400) begin
            tick(1);
            n++;
        end
        check(tag, {15'b0, txsta_out[1] & txif}, 16'd1);
        tick(20);
    endtask

    // Called on the cycle TXD is first seen low; 16 clocks per bit.
    task automatic check_frame(input string tag, input logic [10:0] bits, input int nbits);
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            check(tag, {15'b0, UART_TXD}, {15'b0, bits[i]});
            if (i == nbits - 1) check("trmt_in_stop", {15'b0, txsta_out[1]}, 16'd0);
            tick(16);
        end
        check("trmt_after_frame", {15'b0, txsta_out[1]}, 16'd1);
    endtask

    initial begin
        // ---- reset ----
        tick(3);
        check("rst_txd", {15'b0, UART_TXD}, 16'd1);
        check("rst_txsta", {8'b0, txsta_out}, 16'h02);
        check("rst_rcsta", {8'b0, rcsta_out}, 16'h00);
        check("rst_spbrg", {8'b0, spbrg_out}, 16'h00);
        check("rst_spbrgh", {8'b0, spbrgh_out}, 16'h00);
        check("rst_txreg", {8'b0, txreg_out}, 16'h00);
        check("rst_rcreg", {8'b0, rcreg_out}, 16'h00);
        check("rst_txif", {15'b0, txif}, 16'd1);
        check("rst_rxif", {15'b0, rxif}, 16'd0);
        rst_n = 1'b1;
        tick(2);

        // ---- loopback 8'hCA, SPBRG=0, BRGH=1 ----
        wr_reg(c_sel_rcsta, 8'h90);
        check("rcsta_wr", {8'b0, rcsta_out}, 16'h90);
        wr_reg(c_sel_txsta, 8'h24);
        check("txsta_wr", {8'b0, txsta_out}, 16'h26);
        wr_reg(c_sel_txreg, 8'hCA);
        check("txreg_rb", {8'b0, txreg_out}, 16'h00CA);
        check("txif_full", {15'b0, txif}, 16'd0);
        tick(1);
        check("txif_popped", {15'b0, txif}, 16'd1);
        check("trmt_busy", {8'b0, txsta_out}, 16'h24);
        wait_txd_fall("fall_ca", 40);
        check_frame("frame_ca", {1'b1, 1'b1, 8'hCA, 1'b0}, 10);
        wait_idle("idle_ca");
        check("rx_ca", {8'b0, rcreg_out}, 16'h00CA);
        check("rxif_ca", {15'b0, rxif}, 16'd1);
        check("rcsta_ca", {8'b0, rcsta_out}, 16'h90);
        pop();
        tick(1);
        check("rxif_pop", {15'b0, rxif}, 16'd0);
        check("rcreg_pop", {8'b0, rcreg_out}, 16'h00);

        // ---- 9-bit frame ----
        wr_reg(c_sel_rcsta, 8'hD0);
        wr_reg(c_sel_txsta, 8'h65);
        check("txsta_9b", {8'b0, txsta_out}, 16'h67);
        wr_reg(c_sel_txreg, 8'h55);
        wait_txd_fall("fall_55", 40);
        check_frame("frame_55", {1'b1, 1'b1, 8'h55, 1'b0}, 11);
        tick(10);
        check("rx_55", {8'b0, rcreg_out}, 16'h0055);
        check("rcsta_rx9d", {8'b0, rcsta_out}, 16'hD1);
        pop();
        tick(1);

        // ---- overrun with RX_DEPTH=2 ----
        wr_reg(c_sel_txsta, 8'h24);
        wr_reg(c_sel_rcsta, 8'h90);
        wr_reg(c_sel_txreg, 8'h01);
        wait_idle("idle_01");
        wr_reg(c_sel_txreg, 8'h02);
        wait_idle("idle_02");
        wr_reg(c_sel_txreg, 8'h03);
        wait_idle("idle_03");
        check("oerr_set", {8'b0, rcsta_out}, 16'h92);
        check("ovr_head1", {8'b0, rcreg_out}, 16'h01);
        pop();
        tick(1);
        check("ovr_head2", {8'b0, rcreg_out}, 16'h02);
        check("ovr_rxif2", {15'b0, rxif}, 16'd1);
        pop();
        tick(1);
        check("ovr_empty", {15'b0, rxif}, 16'd0);
        wr_reg(c_sel_rcsta, 8'h80);
        check("oerr_clr", {8'b0, rcsta_out}, 16'h80);
        wr_reg(c_sel_rcsta, 8'h90);
        wr_reg(c_sel_txreg, 8'h04);
        wait_idle("idle_04");
        check("rx_after_ovr", {8'b0, rcreg_out}, 16'h04);
        pop();
        tick(1);

        // ---- framing error: line held low through the stop bit ----
        loop_en   = 1'b0;
        rxd_force = 1'b0;
        tick(170);
        rxd_force = 1'b1;
        tick(20);
        check("ferr_rxif", {15'b0, rxif}, 16'd1);
        check("ferr_data", {8'b0, rcreg_out}, 16'h00);
        check("ferr_flag", {8'b0, rcsta_out}, 16'h94);
        pop();
        tick(1);
        check("ferr_popped", {8'b0, rcsta_out}, 16'h90);

        // ---- false start: 3-clock glitch ----
        rxd_force = 1'b0;
        tick(3);
        rxd_force = 1'b1;
        tick(40);
        check("glitch_nopush", {15'b0, rxif}, 16'd0);
        loop_en = 1'b1;
        wr_reg(c_sel_txreg, 8'h3C);
        wait_idle("idle_3c");
        check("rx_after_glitch", {8'b0, rcreg_out}, 16'h3C);
        pop();
        tick(1);

        // ---- 16-bit divisor, BRGH=0: 64*257 clocks per bit ----
        wr_reg(c_sel_spbrgh, 8'h01);
        check("spbrgh_rb", {8'b0, spbrgh_out}, 16'h01);
        wr_reg(c_sel_txsta, 8'h20);
        wr_reg(c_sel_txreg, 8'h01);
        wait_txd_fall("fall_brg16", 17000);
        tick(16446);
        check("brg16_start", {15'b0, UART_TXD}, 16'd0);
        tick(4);
        check("brg16_bit0", {15'b0, UART_TXD}, 16'd1);
        tick(16448);
        check("brg16_bit1", {15'b0, UART_TXD}, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_txd", {15'b0, UART_TXD}, 16'd1);
        check("async_rst_txsta", {8'b0, txsta_out}, 16'h02);
        check("async_rst_rcsta", {8'b0, rcsta_out}, 16'h00);
        check("async_rst_spbrgh", {8'b0, spbrgh_out}, 16'h00);
        check("async_rst_txif", {15'b0, txif}, 16'd1);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_txd", {15'b0, UART_TXD}, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
